// File: rtl/gtxe2_chnl_cpll_rstseq_pkg.sv
// rtl/gtxe2_chnl_cpll_rstseq_pkg.sv - CPLL reset sequencer state encodings and phase output decode
package gtxe2_chnl_cpll_rstseq_pkg;

   localparam int RETRY_W = 4;

   typedef enum logic [2:0] {
      ST_PD        = 3'd0,
      ST_RST       = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_LOCKED    = 3'd3,
      ST_RETRY     = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   typedef struct packed {
      logic pd;
      logic rst;
      logic done;
      logic fail;
   } phase_out_t;

   // pd is only ever raised together with rst, so the CPLL never sees pd without reset
   function automatic phase_out_t phase_decode(state_t s);
      phase_out_t o;
      o = '{pd: 1'b1, rst: 1'b1, done: 1'b0, fail: 1'b0};
      case (s)
         ST_PD:        o = '{pd: 1'b1, rst: 1'b1, done: 1'b0, fail: 1'b0};
         ST_RST:       o = '{pd: 1'b0, rst: 1'b1, done: 1'b0, fail: 1'b0};
         ST_WAIT_LOCK: o = '{pd: 1'b0, rst: 1'b0, done: 1'b0, fail: 1'b0};
         ST_LOCKED:    o = '{pd: 1'b0, rst: 1'b0, done: 1'b1, fail: 1'b0};
         ST_RETRY:     o = '{pd: 1'b0, rst: 1'b1, done: 1'b0, fail: 1'b0};
         ST_FAIL:      o = '{pd: 1'b1, rst: 1'b1, done: 1'b0, fail: 1'b1};
         default:      o = '{pd: 1'b1, rst: 1'b1, done: 1'b0, fail: 1'b0};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/gtxe2_chnl_cpll_rstseq_if.sv
// rtl/gtxe2_chnl_cpll_rstseq_if.sv - sequencer <-> CPLL/control signal bundle
interface gtxe2_chnl_cpll_rstseq_if;
   import gtxe2_chnl_cpll_rstseq_pkg::*;

   logic               restart;
   logic               cpll_lock;
   logic               cpll_pd;
   logic               cpll_reset;
   logic               done;
   logic               fail;
   logic [RETRY_W-1:0] retry_cnt;
   logic [2:0]         state_o;

   modport master (
      input  restart, cpll_lock,
      output cpll_pd, cpll_reset, done, fail, retry_cnt, state_o
   );

   modport slave (
      output restart, cpll_lock,
      input  cpll_pd, cpll_reset, done, fail, retry_cnt, state_o
   );
endinterface

// File: rtl/gtxe2_chnl_sync2.sv
// rtl/gtxe2_chnl_sync2.sv - two-flop synchronizer, async active-low reset to 0
module gtxe2_chnl_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/gtxe2_chnl_cpll_rstseq.sv
// rtl/gtxe2_chnl_cpll_rstseq.sv - CPLL power-down/reset sequencer with lock debounce and bounded retry
module gtxe2_chnl_cpll_rstseq
   import gtxe2_chnl_cpll_rstseq_pkg::*;
#(
   parameter int PD_CYCLES    = 16,
   parameter int RST_CYCLES   = 8,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int LOCK_STABLE  = 4,
   parameter int MAX_RETRY    = 3,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gtxe2_chnl_cpll_rstseq_if.master bus
);
   localparam logic [CNT_W-1:0]   PD_LAST   = CNT_W'(PD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_N  = CNT_W'(LOCK_STABLE);
   localparam logic [CNT_W-1:0]   TIMER_MAX = '1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   timer, stable, stable_nxt;
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
   phase_out_t         outs;
   logic               lock_s;
   logic               enter;

   gtxe2_chnl_sync2 u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.cpll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_nxt  = state;
      stable_nxt = '0;
      retry_nxt  = retry_cnt;
      case (state)
         ST_PD:  if (timer == PD_LAST) state_nxt = ST_RST;
         ST_RST: if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            stable_nxt = lock_s ? stable + 1'b1 : '0;
            // a lock completing on the timeout cycle still counts as locked
            if (stable_nxt == STABLE_N)  state_nxt = ST_LOCKED;
            else if (timer == TO_LAST)   state_nxt = ST_RETRY;
         end
         ST_LOCKED: if (!lock_s) state_nxt = ST_RETRY;
         ST_RETRY: begin
            if (retry_cnt < RETRY_MAX) begin
               retry_nxt = retry_cnt + 1'b1;
               state_nxt = ST_RST;
            end else begin
               state_nxt = ST_FAIL;
            end
         end
         ST_FAIL: state_nxt = ST_FAIL;
         default: state_nxt = ST_PD;
      endcase
      if (bus.restart) begin
         state_nxt  = ST_PD;
         retry_nxt  = '0;
         stable_nxt = '0;
      end
   end

   // restart re-enters PD even from PD, so the full power-down phase is replayed
   assign enter = bus.restart || (state_nxt != state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_PD;
         timer     <= '0;
         stable    <= '0;
         retry_cnt <= '0;
         outs      <= phase_decode(ST_PD);
      end else begin
         state     <= state_nxt;
         stable    <= stable_nxt;
         retry_cnt <= retry_nxt;
         outs      <= phase_decode(state_nxt);
         if (enter)                  timer <= '0;
         else if (timer != TIMER_MAX) timer <= timer + 1'b1;
      end
   end

   assign bus.cpll_pd    = outs.pd;
   assign bus.cpll_reset = outs.rst;
   assign bus.done       = outs.done;
   assign bus.fail       = outs.fail;
   assign bus.retry_cnt  = retry_cnt;
   assign bus.state_o    = state;
endmodule
